mem_wr_seq: RTL and testbench

//   Burst write sequencer that sits directly upstream of the byte memory block and drives its wr/wdata write port.
//   A burst is started with a base address and a beat count.
//   The block then pulls bytes from an upstream stream using a valid/ready handshake.
//   It issues one registered memory write per accepted byte, at consecutive (wrapping) addresses.
//   It signals completion with a one-cycle done pulse.

---
 rtl/mem_wr_seq.sv | 112 +++++++++++
 tb/tb_mem_wr_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_wr_seq.sv
`default_nettype none
// mem_wr_seq: burst write sequencer that pulls a valid/ready byte stream and issues
// one registered memory write per accepted beat at consecutive wrapping addresses.
module mem_wr_seq #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [LEN_W-1:0] len,
  input  logic             s_valid,
  input  logic [DW-1:0]    s_data,
  output logic             s_ready,
  output logic             wr,
  output logic [AW-1:0]    waddr,
  output logic [DW-1:0]    wdata,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [AW-1:0]    ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO = '0;

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             wr_q, wr_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             err_q, err_d;
  logic             beat_acc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    wr_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    beat_acc = s_valid && (state_q == S_WRITE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != LEN_ZERO) begin
            state_d = S_WRITE;
            addr_d  = base_addr;
            rem_d   = len;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WRITE: begin
        if (beat_acc) begin
          wr_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = s_data;
          addr_d  = addr_q + ADDR_ONE;
          rem_d   = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A reject landing on the last-beat edge would collide with done; done takes priority.
    err_d = start && (state_q != S_IDLE) && (state_d != S_DONE);
  end

  assign s_ready = (state_q == S_WRITE);
  assign busy    = (state_q == S_WRITE);
  assign done    = (state_q == S_DONE);
  assign wr      = wr_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wr_seq.sv
`default_nettype none
// tb_mem_wr_seq: scoreboard bench; expected writes queued as beats are driven,
// popped and compared whenever the DUT raises wr.
module tb_mem_wr_seq;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic [LEN_W-1:0] len;
  logic             s_valid;
  logic [DW-1:0]    s_data;
  logic             s_ready;
  logic             wr;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic             busy;
  logic             done;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+DW-1:0] sb_q[$];
  logic [AW+DW-1:0] sb_e;

  always #5 clk = ~clk;

  mem_wr_seq #(.DW(DW), .AW(AW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .wr(wr),
    .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Every write strobe must match the oldest outstanding expected beat.
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("wr_unexpected", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        chk("waddr", 32'(waddr), 32'(sb_e[AW+DW-1:DW]));
        chk("wdata", 32'(wdata), 32'(sb_e[DW-1:0]));
      end
    end
  end

  // Called at posedge+1; vpat bit i gives s_valid in the i-th cycle after start.
  // inj >= 0 pulses a bogus start in that cycle, expecting err one cycle later.
  task automatic run_burst(input logic [AW-1:0] b, input logic [LEN_W-1:0] n,
                           input logic [31:0] vpat, input logic [DW-1:0] d0,
                           input logic [DW-1:0] dstep, input int inj);
    logic [AW-1:0] a;
    logic [DW-1:0] dv;
    int            beat;
    int            i;
    logic          prev_acc;
    a = b; dv = d0; beat = 0; i = 0; prev_acc = 1'b0;
    start = 1'b1; base_addr = b; len = n; s_valid = 1'b1; s_data = 8'hEE;
    @(negedge clk);
    chk("idle_ready", 32'(s_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    cyc();
    while (beat < int'(n) && i < 64) begin
      start     = (inj >= 0) && (i == inj);
      base_addr = ~b;
      len       = n + 5'd1;
      s_valid   = vpat[i % 32];
      s_data    = dv;
      if (s_valid) sb_q.push_back({a, dv});
      @(negedge clk);
      chk("wr_ready", 32'(s_ready), 32'd1);
      chk("wr_busy", 32'(busy), 32'd1);
      chk("wr_strobe", 32'(wr), 32'(prev_acc));
      chk("wr_done", 32'(done), 32'd0);
      chk("wr_err", 32'(err), 32'((inj >= 0) && (i == inj + 1)));
      prev_acc = s_valid;
      if (s_valid) begin
        a++; dv += dstep; beat++;
      end
      i++;
      cyc();
    end
    chk("burst_timeout", 32'(beat < int'(n)), 32'd0);
    start = 1'b0; s_valid = 1'b1; s_data = 8'h77;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_ready", 32'(s_ready), 32'd0);
    chk("done_last_wr", 32'(wr), 32'd1);
    chk("done_err", 32'(err), 32'd0);
    cyc();
    s_valid = 1'b0;
    @(negedge clk);
    chk("post_done", 32'(done), 32'd0);
    chk("post_wr", 32'(wr), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    cyc();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; len = '0; s_valid = 1'b0; s_data = '0;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_outputs", {25'd0, s_ready, wr, busy, done, err, 2'b00}, 32'd0);
    chk("rst_data", {20'd0, waddr, wdata}, 32'd0);
    cyc();
    rst = 1'b1;

    run_burst(4'd2, 5'd3, 32'hFFFF_FFFF, 8'hA1, 8'h11, -1);
    run_burst(4'd14, 5'd4, 32'hFFFF_FFFF, 8'h01, 8'h01, -1);
    run_burst(4'd5, 5'd3, 32'h0000_0029, 8'h40, 8'h01, -1);

    // Zero-length request: done one cycle after start, no writes.
    start = 1'b1; len = '0; base_addr = 4'd7; s_valid = 1'b1; s_data = 8'h55;
    @(negedge clk);
    chk("len0_done_early", 32'(done), 32'd0);
    cyc();
    start = 1'b0;
    @(negedge clk);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_wr", 32'(wr), 32'd0);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_ready", 32'(s_ready), 32'd0);
    cyc();
    @(negedge clk);
    chk("len0_after", {29'd0, done, wr, err}, 32'd0);
    cyc();
    s_valid = 1'b0;

    run_burst(4'd9, 5'd3, 32'hFFFF_FFFF, 8'h10, 8'h03, 1);

    // Reset after three accepted beats of an 8-beat burst.
    start = 1'b1; base_addr = 4'd3; len = 5'd8;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data  = 8'hC0 + 8'(k);
      sb_q.push_back({4'(4'd3 + 4'(k)), s_data});
      cyc();
    end
    rst = 1'b0; s_data = 8'hCF;
    cyc();
    @(negedge clk);
    chk("rstmid_outputs", {25'd0, s_ready, wr, busy, done, err, 2'b00}, 32'd0);
    chk("rstmid_data", {20'd0, waddr, wdata}, 32'd0);
    chk("rstmid_sb", 32'(sb_q.size()), 32'd0);
    cyc();
    rst = 1'b1; s_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("rstmid_no_done", {30'd0, done, wr}, 32'd0);
    cyc();

    run_burst(4'd0, 5'd31, 32'hFFFF_FFFF, 8'h00, 8'h01, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
